// File: rtl/dff_pkg.sv
// Shared constants for the storage-element library built on dff.
// Defaults here match the scalar flop used by existing benches.
package dff_pkg;

  localparam int unsigned DFF_WIDTH_DEFAULT = 32'd1;

endpackage : dff_pkg

// File: rtl/dff.sv
// Edge-triggered D flip-flop with synchronous active-high clear (inz) and load enable (Re).
// Wider registers and shift chains instantiate this block rather than duplicating it.
module dff
  import dff_pkg::*;
#(
  parameter int unsigned            WIDTH   = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0]       RST_VAL = '0
) (
  input  logic             clk,
  input  logic             inz,
  input  logic             Re,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  // Clear has priority over the enable, and the enable does not gate the clear.
  always_ff @(posedge clk) begin
    if (inz) begin
      Q <= RST_VAL;
    end else if (Re) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule : dff

// File: tb/tb_dff.sv
// Directed bench for dff: a scalar instance driven from a vector table,
// plus a byte-wide instance with a non-zero clear value.
module tb_dff;

  typedef struct packed {
    logic d;
    logic inz;
    logic clk;
    logic re;
    logic exp_q;
  } vec_t;

  logic       clk;
  logic       inz;
  logic       re;
  logic       d;
  logic       q;
  logic [7:0] d8;
  logic [7:0] q8;

  int  passed;
  int  total;
  time last_rise;

  dff #(.WIDTH(1), .RST_VAL(1'b0)) dut (
    .clk(clk), .inz(inz), .Re(re), .D(d), .Q(q)
  );

  dff #(.WIDTH(8), .RST_VAL(8'h5A)) dut_w (
    .clk(clk), .inz(inz), .Re(re), .D(d8), .Q(q8)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total = total + 1;
    if (act === exp) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One 50 ns step: inputs settle first, then clk moves, Q sampled mid-step.
  task automatic apply(input vec_t v, input int idx);
    d   = v.d;
    inz = v.inz;
    re  = v.re;
    #1;
    clk = v.clk;
    #24;
    check($sformatf("vec%0d", idx), {7'd0, q}, {7'd0, v.exp_q});
    #25;
  endtask

  // Full clock pulse for the byte-wide sequences.
  task automatic pulse;
    #1;
    clk = 1'b1;
    #24;
    clk = 1'b0;
    #25;
  endtask

  always @(posedge clk) last_rise = $time;

  // Q may only move at the instant of a rising clk edge.
  always @(q or q8) begin
    if ($time != 0) begin
      check("q_edge_only", {7'd0, ($time == last_rise)}, 8'd1);
    end
  end

  vec_t vecs[$];

  initial begin
    passed    = 0;
    total     = 0;
    last_rise = 0;
    clk       = 1'b0;
    inz       = 1'b0;
    re        = 1'b0;
    d         = 1'b0;
    d8        = 8'h00;

    // {d, inz, clk, re, exp_q}
    vecs = '{
      // load 1, then load 0
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0},
      // sync clear from Q=1; falling edge has no effect
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0},
      // clear, release while clk high, fall, then next rise loads
      '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1},
      // enable low holds 1
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1}, '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      // get Q=0, enable low holds 0
      '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0},
      // clear beats enable-low
      '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0}, '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0}
    };

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], i);
    end

    // Level insensitivity: load 1, then wiggle inputs with clk high, then low.
    apply('{1'b1, 1'b0, 1'b1, 1'b1, 1'b1}, 100);
    for (int i = 0; i < 6; i++) begin
      d   = i[0];
      re  = ~i[1];
      inz = (i == 3);
      #5;
      check("hold_clk_high", {7'd0, q}, 8'd1);
    end
    clk = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d   = ~i[0];
      re  = i[1];
      inz = (i == 2);
      #5;
      check("hold_clk_low", {7'd0, q}, 8'd1);
    end
    #20;

    // Byte-wide instance: clear value, load, hold, clear with enable low.
    inz = 1'b1; re = 1'b1; d8 = 8'hC3; d = 1'b1;
    pulse();
    check("w_clear", q8, 8'h5A);
    inz = 1'b0; re = 1'b1; d8 = 8'hC3;
    pulse();
    check("w_load", q8, 8'hC3);
    re = 1'b0; d8 = 8'h0F;
    pulse();
    check("w_hold", q8, 8'hC3);
    re = 1'b1; d8 = 8'h81;
    pulse();
    check("w_load2", q8, 8'h81);
    inz = 1'b1; re = 1'b0; d8 = 8'hFF;
    pulse();
    check("w_clear_re0", q8, 8'h5A);
    check("s_clear_re0", {7'd0, q}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_dff
